// File: rtl/alu_seq_pkg.sv
// Shared types and helpers for the nibble-serial ALU adder.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int NIB_W = 4;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((32'sd1 <<< r) < n) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/cla_4_bit_slice.sv
// 4-bit carry-lookahead slice; prop/gen exported so it can also serve a block-CLA.
module cla_4_bit_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] sum,
  output logic       c_out,
  output logic       prop,
  output logic       gen
);

  logic [3:0] p;
  logic [3:0] g;
  logic [3:0] c;

  assign p = a ^ b;
  assign g = a & b;

  assign c[0] = c_in;
  assign c[1] = g[0] | (p[0] & c_in);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c_in);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & c_in);

  assign gen   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign prop  = &p;
  assign c_out = gen | (prop & c_in);
  assign sum   = p ^ c;

endmodule

// File: rtl/cla_nibble_sequencer.sv
// Multi-cycle add/sub: one 4-bit CLA slice reused over WIDTH/4 cycles with a
// registered carry between nibbles, wrapped in valid/ready request/response.
module cla_nibble_sequencer
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic             req_sub,
  input  logic             req_cin,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             busy
);

  localparam int NIB   = WIDTH / NIB_W;
  localparam int CNT_W = (clog2(NIB) > 0) ? clog2(NIB) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [3:0] slice_sum;
  logic       slice_cout;
  logic       slice_prop;
  logic       slice_gen;
  logic       unused_slice_pg;

  cla_4_bit_slice u_slice (
    .a     (opa_q[3:0]),
    .b     (opb_q[3:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout),
    .prop  (slice_prop),
    .gen   (slice_gen)
  );

  assign unused_slice_pg = slice_prop ^ slice_gen;

  // DONE with rsp_ready high doubles as an accept slot for back-to-back ops.
  assign req_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && rsp_ready);
  assign rsp_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_sum   = sum_q;
  assign rsp_cout  = carry_q;
  assign rsp_ovf   = ovf_q;
  assign rsp_zero  = zero_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (req_valid && req_ready) begin
          opa_d   = req_a;
          opb_d   = req_sub ? ~req_b : req_b;
          carry_d = req_sub ? 1'b1 : req_cin;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          zero_d  = 1'b0;
          state_d = S_RUN;
        end else if (state_q == S_DONE && rsp_ready) begin
          state_d = S_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      S_RUN: begin
        // LSB-first: each new nibble enters at the top and slides down.
        sum_d   = {slice_sum, sum_q[WIDTH-1:NIB_W]};
        opa_d   = {{NIB_W{1'b0}}, opa_q[WIDTH-1:NIB_W]};
        opb_d   = {{NIB_W{1'b0}}, opb_q[WIDTH-1:NIB_W]};
        carry_d = slice_cout;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(NIB - 1)) begin
          ovf_d   = (opa_q[3] == opb_q[3]) && (slice_sum[3] != opa_q[3]);
          zero_d  = (sum_d == '0);
          state_d = S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

endmodule

// File: tb/tb_cla_nibble_sequencer.sv
// Directed bench for cla_nibble_sequencer (WIDTH=32) with hand-computed results.
module tb_cla_nibble_sequencer;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        req_sub;
  logic        req_cin;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_sum;
  logic        rsp_cout;
  logic        rsp_ovf;
  logic        rsp_zero;
  logic        busy;

  int checks;
  int failures;

  cla_nibble_sequencer #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_cin   (req_cin),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_sum   (rsp_sum),
    .rsp_cout  (rsp_cout),
    .rsp_ovf   (rsp_ovf),
    .rsp_zero  (rsp_zero),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, ".rsp_sum"},   64'(rsp_sum),   64'd0);
    check_eq({tag, ".rsp_cout"},  64'(rsp_cout),  64'd0);
    check_eq({tag, ".rsp_ovf"},   64'(rsp_ovf),   64'd0);
    check_eq({tag, ".rsp_zero"},  64'(rsp_zero),  64'd0);
    check_eq({tag, ".busy"},      64'(busy),      64'd0);
  endtask

  // Present a request at a negedge; returns after the accepting posedge.
  task automatic send_req(input logic [31:0] a, input logic [31:0] b,
                          input logic sub, input logic cin, input string tag);
    @(negedge clk);
    req_a     = a;
    req_b     = b;
    req_sub   = sub;
    req_cin   = cin;
    req_valid = 1'b1;
    #1;
    check_eq({tag, ".req_ready"}, 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_a     = ~a;
    req_b     = 32'h5A5A_5A5A;
    req_sub   = ~sub;
    req_cin   = ~cin;
  endtask

  // Accept edge counts as edge 1; the result must appear after edge 9, not 8.
  task automatic wait_result(input string tag);
    for (int n = 2; n <= 9; n++) begin
      if (n != 2) begin
        @(posedge clk);
        #1;
      end else begin
        check_eq({tag, ".busy_run"}, 64'(busy), 64'd1);
        check_eq({tag, ".ready_run"}, 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
      end
      if (n == 8) check_eq({tag, ".valid_early"}, 64'(rsp_valid), 64'd0);
    end
    check_eq({tag, ".rsp_valid"}, 64'(rsp_valid), 64'd1);
  endtask

  task automatic check_rsp(input logic [31:0] s, input logic c, input logic o,
                           input logic z, input string tag);
    check_eq({tag, ".sum"},  64'(rsp_sum),  64'(s));
    check_eq({tag, ".cout"}, 64'(rsp_cout), 64'(c));
    check_eq({tag, ".ovf"},  64'(rsp_ovf),  64'(o));
    check_eq({tag, ".zero"}, 64'(rsp_zero), 64'(z));
  endtask

  task automatic handshake(input string tag);
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    check_eq({tag, ".valid_drop"}, 64'(rsp_valid), 64'd0);
    check_eq({tag, ".idle_ready"}, 64'(req_ready), 64'd1);
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                       input logic cin, input logic [31:0] s, input logic c,
                       input logic o, input logic z, input string tag);
    send_req(a, b, sub, cin, tag);
    wait_result(tag);
    check_rsp(s, c, o, z, tag);
    handshake(tag);
  endtask

  logic [31:0] held_sum;
  bit          saw_valid;

  initial begin
    checks    = 0;
    failures  = 0;
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_a     = 32'h0;
    req_b     = 32'h0;
    req_sub   = 1'b0;
    req_cin   = 1'b0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    do_op(32'h0000_0004, 32'h0000_0009, 1'b0, 1'b0, 32'h0000_000D, 1'b0, 1'b0, 1'b0, "add");
    do_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "ripple");
    do_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0, "ovf_add");
    do_op(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, "ovf_sub");
    do_op(32'h1234_5678, 32'h1234_5678, 1'b1, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1, "sub_eq");
    do_op(32'h0000_000F, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0010, 1'b0, 1'b0, 1'b0, "adc");

    // Backpressure, with the next request waiting the whole time.
    send_req(32'hA5A5_0000, 32'h0000_5A5A, 1'b0, 1'b0, "bp");
    wait_result("bp");
    held_sum = 32'hA5A5_5A5A;
    @(negedge clk);
    req_a     = 32'h0000_0009;
    req_b     = 32'h0000_000A;
    req_sub   = 1'b0;
    req_cin   = 1'b0;
    req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp.valid_hold", 64'(rsp_valid), 64'd1);
      check_eq("bp.busy_hold",  64'(busy),      64'd1);
      check_eq("bp.ready_hold", 64'(req_ready), 64'd0);
      check_eq("bp.sum_hold",   64'(rsp_sum),   64'(held_sum));
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    #1;
    check_eq("b2b.req_ready", 64'(req_ready), 64'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    rsp_ready = 1'b0;
    req_a     = 32'hFFFF_FFFF;
    check_eq("b2b.valid_drop", 64'(rsp_valid), 64'd0);
    wait_result("b2b");
    check_rsp(32'h0000_0013, 1'b0, 1'b0, 1'b0, "b2b");
    handshake("b2b");

    // Reset during RUN aborts immediately and never shows a result.
    send_req(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, "rst_run");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_run");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (rsp_valid) saw_valid = 1'b1;
    end
    check_eq("rst_run.no_valid", 64'(saw_valid), 64'd0);
    check_eq("rst_run.ready", 64'(req_ready), 64'd1);
    rsp_ready = 1'b0;
    do_op(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
